// File: rtl/jtpang_romrd.sv
// Single-slot ROM read front-end: turns a level cs/addr request into one SDRAM
// req/ack burst and keeps the last fetched word(s) as a one-entry cache.
module jtpang_romrd #(
    parameter int          DW      = 8,
    parameter int          AW      = 18,
    parameter logic [21:0] OFFSET  = 22'h0,
    parameter bit          OKLATCH = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slot_cs,
    input  logic [AW-1:0] slot_addr,
    output logic [DW-1:0] slot_dout,
    output logic          slot_ok,
    output logic          sdram_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic          data_rdy,
    input  logic [15:0]   data_read
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WAIT2,
        ST_FILL
    } state_t;

    // Slot address to 16-bit SDRAM word address, wrapping modulo 2^22.
    function automatic logic [21:0] word_addr(input logic [AW-1:0] a);
        logic [21:0] w;
        if (DW == 8)
            w = 22'(a >> 1);
        else if (DW == 32)
            w = 22'({a, 1'b0});
        else
            w = 22'(a);
        return w + OFFSET;
    endfunction

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [21:0] addr_q, addr_d;
    logic [15:0] buf0_q, buf0_d;
    logic [15:0] buf1_q, buf1_d;
    logic        valid_q, valid_d;
    logic [21:0] tag_q, tag_d;
    logic [15:0] cw0_q, cw0_d;
    logic [15:0] cw1_q, cw1_d;
    logic        ok_q, ok_d;

    logic [21:0] cur_word;
    logic        hit;
    logic [31:0] cache_data;
    logic [4:0]  lane_sh;

    assign cur_word = word_addr(slot_addr);
    assign hit      = valid_q && (tag_q == cur_word);

    always_comb begin
        // NOTE: every *_d gets its held value first so no path can infer a latch.
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        cw0_d   = cw0_q;
        cw1_d   = cw1_q;

        case (state_q)
            ST_IDLE: begin
                if (slot_cs && !hit) begin
                    req_d   = 1'b1;
                    addr_d  = cur_word;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_dst) begin
                    buf0_d  = data_read;
                    state_d = (DW == 32) ? ST_WAIT2 : ST_FILL;
                end
            end
            ST_WAIT2: begin
                if (data_rdy) begin
                    buf1_d  = data_read;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                valid_d = 1'b1;
                tag_d   = addr_q;
                cw0_d   = buf0_q;
                cw1_d   = buf1_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Look at the cache as it will be after this edge, so ok rises together with the fill.
        ok_d = slot_cs && valid_d && (tag_d == cur_word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            // NOTE: the cache data words are reset as well, so slot_dout reads zero out of reset.
            cw0_q   <= '0;
            cw1_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cw0_q   <= cw0_d;
            cw1_q   <= cw1_d;
            ok_q    <= ok_d;
        end
    end

    assign cache_data = {cw1_q, cw0_q};

    always_comb begin
        lane_sh = '0;
        if (DW == 8)
            lane_sh = {1'b0, slot_addr[0], 3'b000};
        slot_dout = DW'(cache_data >> lane_sh);
    end

    assign slot_ok    = OKLATCH ? ok_q : (slot_cs && hit);
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtpang_romrd.sv
// Bench for jtpang_romrd: four parameterisations, a cycle table, directed
// corner cases and a random run against a cache/memory reference model.
module tb_jtpang_romrd;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_v   [4];
    logic [17:0] addr_v [4];
    logic        ack_v  [4];
    logic        dst_v  [4];
    logic        rdy_v  [4];
    logic [15:0] rd_v   [4];
    logic        req_v  [4];
    logic [21:0] saddr_v[4];
    logic        ok_v   [4];
    logic [31:0] dout_v [4];
    logic [15:0] dout16;
    logic [7:0]  dout8;
    logic [31:0] dout32;
    logic [15:0] dout_off;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign dout_v[0] = {16'h0, dout16};
    assign dout_v[1] = {24'h0, dout8};
    assign dout_v[2] = dout32;
    assign dout_v[3] = {16'h0, dout_off};

    jtpang_romrd #(.DW(16), .AW(18), .OFFSET(22'h0), .OKLATCH(1'b1)) u_dw16 (
        .clk(clk), .rst(rst), .slot_cs(cs_v[0]), .slot_addr(addr_v[0]),
        .slot_dout(dout16), .slot_ok(ok_v[0]), .sdram_req(req_v[0]),
        .sdram_addr(saddr_v[0]), .sdram_ack(ack_v[0]), .data_dst(dst_v[0]),
        .data_rdy(rdy_v[0]), .data_read(rd_v[0]));

    jtpang_romrd #(.DW(8), .AW(18), .OFFSET(22'h0), .OKLATCH(1'b1)) u_dw8 (
        .clk(clk), .rst(rst), .slot_cs(cs_v[1]), .slot_addr(addr_v[1]),
        .slot_dout(dout8), .slot_ok(ok_v[1]), .sdram_req(req_v[1]),
        .sdram_addr(saddr_v[1]), .sdram_ack(ack_v[1]), .data_dst(dst_v[1]),
        .data_rdy(rdy_v[1]), .data_read(rd_v[1]));

    jtpang_romrd #(.DW(32), .AW(18), .OFFSET(22'h0), .OKLATCH(1'b1)) u_dw32 (
        .clk(clk), .rst(rst), .slot_cs(cs_v[2]), .slot_addr(addr_v[2]),
        .slot_dout(dout32), .slot_ok(ok_v[2]), .sdram_req(req_v[2]),
        .sdram_addr(saddr_v[2]), .sdram_ack(ack_v[2]), .data_dst(dst_v[2]),
        .data_rdy(rdy_v[2]), .data_read(rd_v[2]));

    jtpang_romrd #(.DW(16), .AW(18), .OFFSET(22'h080000), .OKLATCH(1'b0)) u_off (
        .clk(clk), .rst(rst), .slot_cs(cs_v[3]), .slot_addr(addr_v[3]),
        .slot_dout(dout_off), .slot_ok(ok_v[3]), .sdram_req(req_v[3]),
        .sdram_addr(saddr_v[3]), .sdram_ack(ack_v[3]), .data_dst(dst_v[3]),
        .data_rdy(rdy_v[3]), .data_read(rd_v[3]));

    typedef struct {
        bit          cs;
        logic [17:0] addr;
        bit          ack;
        bit          dst;
        bit          rdy;
        logic [15:0] data;
        bit          req;
        logic [21:0] saddr;
        bit          ok;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Plays the SDRAM side of one transaction for instance i.
    task automatic serve(input int i, input logic [21:0] exp_a, input logic [15:0] w0,
                         input logic [15:0] w1, input bit two, input int ack_dly,
                         input int dat_dly, input bit chg, input logic [17:0] chg_addr);
        int n;
        n = 0;
        while (req_v[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("inst%0d req_rise", i), {31'h0, req_v[i]}, 32'h1);
        if (req_v[i] !== 1'b1) return;
        check($sformatf("inst%0d req_addr", i), {10'h0, saddr_v[i]}, {10'h0, exp_a});
        repeat (ack_dly) @(negedge clk);
        check($sformatf("inst%0d req_hold", i), {31'h0, req_v[i]}, 32'h1);
        ack_v[i] = 1'b1;
        @(negedge clk);
        ack_v[i] = 1'b0;
        check($sformatf("inst%0d req_drop", i), {31'h0, req_v[i]}, 32'h0);
        if (chg) addr_v[i] = chg_addr;
        repeat (dat_dly) @(negedge clk);
        dst_v[i] = 1'b1;
        rdy_v[i] = !two;
        rd_v[i]  = w0;
        @(negedge clk);
        dst_v[i] = 1'b0;
        rdy_v[i] = 1'b0;
        if (two) begin
            repeat (dat_dly) @(negedge clk);
            rdy_v[i] = 1'b1;
            rd_v[i]  = w1;
            @(negedge clk);
            rdy_v[i] = 1'b0;
        end
        rd_v[i] = 16'h0;
    endtask

    // Reference ROM contents: an arbitrary but fixed word per SDRAM address.
    function automatic logic [15:0] mem(input logic [21:0] w);
        logic [31:0] t;
        t = 32'(w) * 32'd40503 + 32'd12345;
        return t[15:0];
    endfunction

    initial begin
        bit          m_valid;
        logic [21:0] m_tag;
        logic [17:0] a;
        logic [21:0] w;
        logic [15:0] mw;
        logic [7:0]  eb;
        int          n;

        tbl[0]  = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h0,   0, 32'h0};
        tbl[1]  = '{1, 18'h123, 0, 0, 0, 16'h0,    1, 22'h123, 0, 32'h0};
        tbl[2]  = '{1, 18'h123, 0, 0, 0, 16'h0,    1, 22'h123, 0, 32'h0};
        tbl[3]  = '{1, 18'h123, 0, 0, 0, 16'h0,    1, 22'h123, 0, 32'h0};
        tbl[4]  = '{1, 18'h123, 1, 0, 0, 16'h0,    1, 22'h123, 0, 32'h0};
        tbl[5]  = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 0, 32'h0};
        tbl[6]  = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 0, 32'h0};
        tbl[7]  = '{1, 18'h123, 0, 1, 1, 16'hBEEF, 0, 22'h123, 0, 32'h0};
        tbl[8]  = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 0, 32'h0};
        tbl[9]  = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 1, 32'hBEEF};
        tbl[10] = '{0, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 1, 32'hBEEF};
        tbl[11] = '{0, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 0, 32'hBEEF};
        tbl[12] = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 0, 32'hBEEF};
        tbl[13] = '{1, 18'h123, 1, 1, 1, 16'h1234, 0, 22'h123, 1, 32'hBEEF};
        tbl[14] = '{1, 18'h123, 0, 0, 0, 16'h0,    0, 22'h123, 1, 32'hBEEF};

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cs_v[i] = 1'b0; addr_v[i] = '0; ack_v[i] = 1'b0;
            dst_v[i] = 1'b0; rdy_v[i] = 1'b0; rd_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst inst%0d req", i), {31'h0, req_v[i]}, 32'h0);
            check($sformatf("rst inst%0d saddr", i), {10'h0, saddr_v[i]}, 32'h0);
            check($sformatf("rst inst%0d ok", i), {31'h0, ok_v[i]}, 32'h0);
            check($sformatf("rst inst%0d dout", i), dout_v[i], 32'h0);
        end
        rst = 1'b0;

        // Cycle table on the DW=16 registered-ok instance.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            cs_v[0] = tbl[k].cs; addr_v[0] = tbl[k].addr; ack_v[0] = tbl[k].ack;
            dst_v[0] = tbl[k].dst; rdy_v[0] = tbl[k].rdy; rd_v[0] = tbl[k].data;
            #1;
            check($sformatf("vec%0d req", k), {31'h0, req_v[0]}, {31'h0, tbl[k].req});
            check($sformatf("vec%0d saddr", k), {10'h0, saddr_v[0]}, {10'h0, tbl[k].saddr});
            check($sformatf("vec%0d ok", k), {31'h0, ok_v[0]}, {31'h0, tbl[k].ok});
            check($sformatf("vec%0d dout", k), dout_v[0], tbl[k].dout);
        end
        @(negedge clk);
        cs_v[0] = 1'b0; ack_v[0] = 1'b0; dst_v[0] = 1'b0; rdy_v[0] = 1'b0; rd_v[0] = '0;

        // DW=8: both bytes of the cached word hit without new traffic.
        @(negedge clk);
        cs_v[1] = 1'b1; addr_v[1] = 18'h246;
        serve(1, 22'h123, 16'hA55A, 16'h0, 1'b0, 2, 1, 1'b0, 18'h0);
        check("dw8 fill ok", {31'h0, ok_v[1]}, 32'h0);
        @(negedge clk);
        check("dw8 ok", {31'h0, ok_v[1]}, 32'h1);
        check("dw8 lo byte", dout_v[1], 32'h5A);
        addr_v[1] = 18'h247;
        #1;
        check("dw8 hi byte", dout_v[1], 32'hA5);
        @(negedge clk);
        check("dw8 hi ok", {31'h0, ok_v[1]}, 32'h1);
        repeat (3) @(negedge clk);
        check("dw8 no req", {31'h0, req_v[1]}, 32'h0);
        cs_v[1] = 1'b0;

        // DW=32: two-word burst.
        @(negedge clk);
        cs_v[2] = 1'b1; addr_v[2] = 18'h100;
        serve(2, 22'h200, 16'h1111, 16'h2222, 1'b1, 1, 2, 1'b0, 18'h0);
        check("dw32 fill ok", {31'h0, ok_v[2]}, 32'h0);
        @(negedge clk);
        check("dw32 ok", {31'h0, ok_v[2]}, 32'h1);
        check("dw32 dout", dout_v[2], 32'h22221111);
        cs_v[2] = 1'b0;

        // Address moves during WAIT: old fetch fills, ok stays low, new fetch follows.
        @(negedge clk);
        cs_v[0] = 1'b1; addr_v[0] = 18'h10;
        serve(0, 22'h10, 16'h1010, 16'h0, 1'b0, 1, 2, 1'b1, 18'h20);
        check("chg fill ok", {31'h0, ok_v[0]}, 32'h0);
        @(negedge clk);
        check("chg ok low", {31'h0, ok_v[0]}, 32'h0);
        check("chg filled old", dout_v[0], 32'h1010);
        serve(0, 22'h20, 16'h2020, 16'h0, 1'b0, 0, 1, 1'b0, 18'h0);
        @(negedge clk);
        check("chg new ok", {31'h0, ok_v[0]}, 32'h1);
        check("chg new dout", dout_v[0], 32'h2020);
        cs_v[0] = 1'b0;

        // Reset while in REQ, then a stray data strobe.
        @(negedge clk);
        cs_v[0] = 1'b1; addr_v[0] = 18'h55;
        n = 0;
        while (req_v[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstx req", {31'h0, req_v[0]}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cs_v[0] = 1'b0;
        check("rstx req low", {31'h0, req_v[0]}, 32'h0);
        check("rstx ok low", {31'h0, ok_v[0]}, 32'h0);
        check("rstx dout", dout_v[0], 32'h0);
        repeat (4) @(negedge clk);
        dst_v[0] = 1'b1; rdy_v[0] = 1'b1; rd_v[0] = 16'hDEAD;
        @(negedge clk);
        dst_v[0] = 1'b0; rdy_v[0] = 1'b0; rd_v[0] = 16'h0;
        @(negedge clk);
        check("stray ok", {31'h0, ok_v[0]}, 32'h0);
        check("stray dout", dout_v[0], 32'h0);
        check("stray req", {31'h0, req_v[0]}, 32'h0);
        cs_v[0] = 1'b1; addr_v[0] = 18'h20;
        @(negedge clk);
        check("rstx invalid req", {31'h0, req_v[0]}, 32'h1);
        check("rstx invalid ok", {31'h0, ok_v[0]}, 32'h0);
        serve(0, 22'h20, 16'h3030, 16'h0, 1'b0, 0, 0, 1'b0, 18'h0);
        @(negedge clk);
        check("rstx refetch ok", {31'h0, ok_v[0]}, 32'h1);
        check("rstx refetch dout", dout_v[0], 32'h3030);
        cs_v[0] = 1'b0;

        // OFFSET wrap-free add and combinational ok.
        @(negedge clk);
        cs_v[3] = 1'b1; addr_v[3] = 18'h3FFFF;
        #1;
        check("off miss ok", {31'h0, ok_v[3]}, 32'h0);
        serve(3, 22'h0BFFFF, 16'h7777, 16'h0, 1'b0, 0, 0, 1'b0, 18'h0);
        check("off fill ok", {31'h0, ok_v[3]}, 32'h0);
        @(negedge clk);
        check("off ok", {31'h0, ok_v[3]}, 32'h1);
        check("off dout", dout_v[3], 32'h7777);
        cs_v[3] = 1'b0;
        #1;
        check("off cs drop", {31'h0, ok_v[3]}, 32'h0);
        @(negedge clk);
        cs_v[3] = 1'b1;
        #1;
        check("off same-cycle ok", {31'h0, ok_v[3]}, 32'h1);
        cs_v[3] = 1'b0;

        // Random reads on the DW=8 instance against a one-entry cache model.
        m_valid = 1'b0;
        m_tag   = '0;
        for (int it = 0; it < 60; it++) begin
            a  = 18'($urandom_range(0, 23));
            w  = 22'(a >> 1);
            mw = mem(w);
            eb = a[0] ? mw[15:8] : mw[7:0];
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                cs_v[1] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check($sformatf("rnd%0d idle ok", it), {31'h0, ok_v[1]}, 32'h0);
            end
            @(negedge clk);
            cs_v[1] = 1'b1; addr_v[1] = a;
            if (m_valid && m_tag == w) begin
                @(negedge clk);
                check($sformatf("rnd%0d hit ok", it), {31'h0, ok_v[1]}, 32'h1);
                check($sformatf("rnd%0d hit dout", it), dout_v[1], {24'h0, eb});
                check($sformatf("rnd%0d hit req", it), {31'h0, req_v[1]}, 32'h0);
            end else begin
                serve(1, w, mw, 16'h0, 1'b0, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b0, 18'h0);
                check($sformatf("rnd%0d fill ok", it), {31'h0, ok_v[1]}, 32'h0);
                @(negedge clk);
                check($sformatf("rnd%0d miss ok", it), {31'h0, ok_v[1]}, 32'h1);
                check($sformatf("rnd%0d miss dout", it), dout_v[1], {24'h0, eb});
                m_valid = 1'b1;
                m_tag   = w;
            end
        end
        cs_v[1] = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
